// File: rtl/dsp_readout.sv
// dsp_readout: read-side sequencer for the dsp shift-register block.
// Steps the dsp word index through a requested number of positions, waits out
// the dsp read latency, captures each dout word and offers it downstream as a
// valid/ready stream with a last-word flag.
//
// Ports:
//   clk       clock, rising edge
//   rst       asynchronous active-high reset
//   start     one-cycle request, sampled only while idle
//   count     number of words to read, latched with start
//   param     word index driven to the dsp param input
//   dsp_dout  data from the dsp dout output
//   m_data    captured word
//   m_valid   m_data is valid
//   m_ready   consumer accepts m_data when m_valid && m_ready
//   m_last    marks the final word of a request
//   busy      high whenever not idle
//   done      one-cycle pulse at request completion
module dsp_readout #(
    parameter int unsigned bus_width  = 24,
    parameter int unsigned num_words  = 2,
    parameter int unsigned rd_latency = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           count,
    output logic [7:0]           param,
    input  logic [bus_width-1:0] dsp_dout,
    output logic [bus_width-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 m_last,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned WAIT_W = 4;
    localparam int unsigned IDX_W  = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t               state_q;
    logic [IDX_W-1:0]     param_q;
    logic [IDX_W-1:0]     rem_q;
    logic [WAIT_W-1:0]    wait_q;
    logic [bus_width-1:0] m_data_q;
    logic                 m_valid_q;
    logic                 m_last_q;
    logic                 busy_q;
    logic                 done_q;
    logic [IDX_W-1:0]     param_d;

    // Next word index, wrapping at num_words.
    always_comb begin
        param_d = param_q + IDX_W'(1);
        if (param_q == IDX_W'(num_words - 1)) begin
            param_d = '0;
        end
    end

    // Sequencer: done is a pulse, so it defaults low every cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            param_q   <= '0;
            rem_q     <= '0;
            wait_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q <= 1'b1;
                        if (count == '0) begin
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end else begin
                            rem_q   <= count;
                            param_q <= '0;
                            wait_q  <= WAIT_W'(rd_latency);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    // Counter reaches zero on the edge dsp_dout shows the new word.
                    if (wait_q != '0) begin
                        wait_q <= wait_q - WAIT_W'(1);
                    end else begin
                        m_data_q  <= dsp_dout;
                        m_valid_q <= 1'b1;
                        m_last_q  <= (rem_q == IDX_W'(1));
                        state_q   <= S_PRESENT;
                    end
                end
                S_PRESENT: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        if (rem_q > IDX_W'(1)) begin
                            rem_q   <= rem_q - IDX_W'(1);
                            param_q <= param_d;
                            wait_q  <= WAIT_W'(rd_latency);
                            state_q <= S_WAIT;
                        end else begin
                            rem_q    <= '0;
                            m_last_q <= 1'b0;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign param   = param_q;
    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign m_last  = m_last_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule
